// File: rtl/sdram_toggle_port.sv
// Multi-channel toggle-handshake front-end for sdram_amr.
// Each channel issues core reads or ioctl download writes and holds one more in a pending slot.
module sdram_toggle_port #(
    parameter int NCH      = 2,
    parameter int AW       = 22,
    parameter int DW       = 16,
    parameter int IDX_BASE = 0
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    ioctl_download,
    input  logic [7:0]              ioctl_index,
    input  logic                    ioctl_wr,
    input  logic [AW-1:0]           ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic                    ioctl_wait,
    input  logic [NCH*(AW-1)-1:0]   core_addr,
    input  logic [NCH-1:0]          core_stb,
    output logic [NCH*DW-1:0]       core_dout,
    output logic [NCH-1:0]          core_valid,
    output logic [NCH-1:0]          core_busy,
    output logic [NCH-1:0]          sd_req,
    input  logic [NCH-1:0]          sd_ack,
    output logic [NCH*AW-1:0]       sd_addr,
    output logic [NCH-1:0]          sd_we,
    output logic [NCH*8-1:0]        sd_din,
    input  logic [NCH*DW-1:0]       sd_dout
);

    logic [NCH-1:0] wait_vec;
    logic           unused_idx;

    assign ioctl_wait = |wait_vec;
    assign unused_idx = ^ioctl_index[7:6];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [5:0] SEL = 6'(IDX_BASE + k);

        logic          req_q, req_d;
        logic          we_q, we_d;
        logic [AW-1:0] addr_q, addr_d;
        logic [7:0]    din_q, din_d;
        logic          pend_q, pend_d;
        logic          pend_we_q, pend_we_d;
        logic [AW-1:0] pend_addr_q, pend_addr_d;
        logic [7:0]    pend_din_q, pend_din_d;
        logic          out_r_q, out_r_d;
        logic [DW-1:0] dout_q, dout_d;
        logic          valid_q, valid_d;
        logic          busy_q, busy_d;

        logic          dl, outst, new_wr, new_rd, pend_live;
        logic [AW-1:0] new_addr;

        always_comb begin
            dl        = ioctl_download && (ioctl_index[5:0] == SEL);
            outst     = req_q ^ sd_ack[k];
            new_wr    = dl && ioctl_wr;
            new_rd    = !ioctl_download && core_stb[k];
            // A pending read never survives into a download.
            pend_live = pend_q && !(ioctl_download && !pend_we_q);
            new_addr  = new_wr ? ioctl_addr : {core_addr[k*(AW-1) +: AW-1], 1'b0};

            req_d       = req_q;
            we_d        = we_q;
            addr_d      = addr_q;
            din_d       = din_q;
            pend_d      = pend_live;
            pend_we_d   = pend_we_q;
            pend_addr_d = pend_addr_q;
            pend_din_d  = pend_din_q;

            if (new_wr || new_rd) begin
                if (!outst) begin
                    req_d  = ~req_q;
                    we_d   = new_wr;
                    addr_d = new_addr;
                    din_d  = new_wr ? ioctl_dout : din_q;
                    pend_d = 1'b0;
                end else if (new_rd || !pend_live) begin
                    pend_d      = 1'b1;
                    pend_we_d   = new_wr;
                    pend_addr_d = new_addr;
                    pend_din_d  = new_wr ? ioctl_dout : pend_din_q;
                end
            end else if (pend_live && !outst) begin
                req_d  = ~req_q;
                we_d   = pend_we_q;
                addr_d = pend_addr_q;
                din_d  = pend_din_q;
                pend_d = 1'b0;
            end

            out_r_d = outst;
            valid_d = out_r_q && !outst && !we_q;
            dout_d  = valid_d ? sd_dout[k*DW +: DW] : dout_q;
            busy_d  = (req_d ^ sd_ack[k]) | pend_d;
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                req_q       <= 1'b0;
                we_q        <= 1'b0;
                addr_q      <= '0;
                din_q       <= '0;
                pend_q      <= 1'b0;
                pend_we_q   <= 1'b0;
                pend_addr_q <= '0;
                pend_din_q  <= '0;
                out_r_q     <= 1'b0;
                dout_q      <= '0;
                valid_q     <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                req_q       <= req_d;
                we_q        <= we_d;
                addr_q      <= addr_d;
                din_q       <= din_d;
                pend_q      <= pend_d;
                pend_we_q   <= pend_we_d;
                pend_addr_q <= pend_addr_d;
                pend_din_q  <= pend_din_d;
                out_r_q     <= out_r_d;
                dout_q      <= dout_d;
                valid_q     <= valid_d;
                busy_q      <= busy_d;
            end
        end

        assign wait_vec[k]             = dl && (outst || (pend_live && pend_we_q));
        assign sd_req[k]               = req_q;
        assign sd_we[k]                = we_q;
        assign sd_addr[k*AW +: AW]     = addr_q;
        assign sd_din[k*8 +: 8]        = din_q;
        assign core_dout[k*DW +: DW]   = dout_q;
        assign core_valid[k]           = valid_q;
        assign core_busy[k]            = busy_q;
    end

endmodule

// File: tb/tb_sdram_toggle_port.sv
// Directed bench for sdram_toggle_port with a delayed-ack controller model.
module tb_sdram_toggle_port;
    localparam int NCH = 2;
    localparam int AW  = 22;
    localparam int DW  = 16;

    logic                  clk_sys = 1'b0;
    logic                  reset_n;
    logic                  ioctl_download;
    logic [7:0]            ioctl_index;
    logic                  ioctl_wr;
    logic [AW-1:0]         ioctl_addr;
    logic [7:0]            ioctl_dout;
    logic                  ioctl_wait;
    logic [NCH*(AW-1)-1:0] core_addr;
    logic [NCH-1:0]        core_stb;
    logic [NCH*DW-1:0]     core_dout;
    logic [NCH-1:0]        core_valid;
    logic [NCH-1:0]        core_busy;
    logic [NCH-1:0]        sd_req;
    logic [NCH-1:0]        sd_ack;
    logic [NCH*AW-1:0]     sd_addr;
    logic [NCH-1:0]        sd_we;
    logic [NCH*8-1:0]      sd_din;
    logic [NCH*DW-1:0]     sd_dout;

    logic [4*(AW-1)-1:0]   core_addr4 = '0;
    logic [3:0]            core_stb4  = '0;
    logic [4*DW-1:0]       core_dout4;
    logic [3:0]            core_valid4;
    logic [3:0]            core_busy4;
    logic [3:0]            sd_req4;
    logic [3:0]            sd_ack4    = '0;
    logic [4*AW-1:0]       sd_addr4;
    logic [3:0]            sd_we4;
    logic [31:0]           sd_din4;
    logic [4*DW-1:0]       sd_dout4   = '0;
    logic                  ioctl_wait4;

    always #5 clk_sys = ~clk_sys;

    sdram_toggle_port #(.NCH(NCH), .AW(AW), .DW(DW), .IDX_BASE(0)) u_dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .core_addr(core_addr), .core_stb(core_stb), .core_dout(core_dout),
        .core_valid(core_valid), .core_busy(core_busy),
        .sd_req(sd_req), .sd_ack(sd_ack), .sd_addr(sd_addr), .sd_we(sd_we),
        .sd_din(sd_din), .sd_dout(sd_dout)
    );

    sdram_toggle_port #(.NCH(4), .AW(AW), .DW(DW), .IDX_BASE(2)) u_dut4 (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait4),
        .core_addr(core_addr4), .core_stb(core_stb4), .core_dout(core_dout4),
        .core_valid(core_valid4), .core_busy(core_busy4),
        .sd_req(sd_req4), .sd_ack(sd_ack4), .sd_addr(sd_addr4), .sd_we(sd_we4),
        .sd_din(sd_din4), .sd_dout(sd_dout4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Controller model: ack toggles dly+1 cycles after a request becomes visible.
    int            dly [NCH];
    int            cnt [NCH];
    logic [DW-1:0] rd_data [NCH];

    initial begin
        sd_ack  = '0;
        sd_dout = '0;
        for (int k = 0; k < NCH; k++) begin
            cnt[k] = 0; dly[k] = 5; rd_data[k] = '0;
        end
        forever begin
            @(posedge clk_sys);
            #1;
            for (int k = 0; k < NCH; k++) begin
                if (sd_req[k] != sd_ack[k]) begin
                    if (cnt[k] == dly[k]) begin
                        sd_ack[k]              = sd_req[k];
                        sd_dout[k*DW +: DW]    = rd_data[k];
                        cnt[k]                 = 0;
                    end else begin
                        cnt[k]++;
                    end
                end
            end
        end
    end

    // Request log and pulse counters, sampled on the falling edge.
    logic [AW-1:0]  addr_log [NCH][8];
    logic           we_log   [NCH][8];
    logic [7:0]     din_log  [NCH][8];
    int             nlog [NCH];
    int             vcnt [NCH];
    int             bcnt [NCH];
    logic [NCH-1:0] prev_req = '0;

    initial begin
        for (int k = 0; k < NCH; k++) begin
            nlog[k] = 0; vcnt[k] = 0; bcnt[k] = 0;
        end
        forever begin
            @(negedge clk_sys);
            for (int k = 0; k < NCH; k++) begin
                if (sd_req[k] != prev_req[k]) begin
                    if (nlog[k] < 8) begin
                        addr_log[k][nlog[k]] = sd_addr[k*AW +: AW];
                        we_log[k][nlog[k]]   = sd_we[k];
                        din_log[k][nlog[k]]  = sd_din[k*8 +: 8];
                    end
                    nlog[k]++;
                end
                if (core_valid[k]) vcnt[k]++;
                if (core_busy[k])  bcnt[k]++;
            end
            prev_req = sd_req;
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic clr();
        for (int k = 0; k < NCH; k++) begin
            nlog[k] = 0; vcnt[k] = 0; bcnt[k] = 0;
        end
    endtask

    task automatic wait_free();
        int w;
        w = 0;
        while (ioctl_wait && w < 50) begin
            step();
            w++;
        end
        chk("wait_free", 32'(ioctl_wait), 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        core_addr      = '0;
        core_stb       = '0;

        // Reset and idle
        #2;
        repeat (3) step();
        chk("rst_req",   32'(sd_req),     32'd0);
        chk("rst_valid", 32'(core_valid), 32'd0);
        chk("rst_busy",  32'(core_busy),  32'd0);
        chk("rst_wait",  32'(ioctl_wait), 32'd0);
        chk("rst_addr",  32'(sd_addr[31:0]), 32'd0);
        chk("rst_dout",  32'(core_dout),  32'd0);
        reset_n = 1'b1;
        clr();
        repeat (100) step();
        chk("idle_req",  32'(sd_req),  32'd0);
        chk("idle_nlog", 32'(nlog[0] + nlog[1]), 32'd0);

        // Single read on ch0
        dly[0] = 5; rd_data[0] = 16'hBEEF;
        clr();
        core_addr[0 +: AW-1] = 21'h1234;
        core_stb = 2'b01;
        step();
        core_stb = 2'b00;
        chk("rd_req",  32'(sd_req[0]), 32'd1);
        chk("rd_addr", 32'(sd_addr[0 +: AW]), 32'h2468);
        chk("rd_we",   32'(sd_we[0]), 32'd0);
        repeat (20) step();
        chk("rd_vcnt", 32'(vcnt[0]), 32'd1);
        chk("rd_dout", 32'(core_dout[0 +: DW]), 32'hBEEF);
        chk("rd_busy", 32'(bcnt[0]), 32'd6);
        chk("rd_nlog", 32'(nlog[0]), 32'd1);

        // Pending slot on ch1: middle strobe overwritten
        dly[1] = 5; rd_data[1] = 16'h1111;
        clr();
        core_addr[AW-1 +: AW-1] = 21'h10; core_stb = 2'b10; step();
        core_addr[AW-1 +: AW-1] = 21'h20; step();
        core_addr[AW-1 +: AW-1] = 21'h30; step();
        core_stb = 2'b00;
        repeat (30) step();
        chk("pend_nlog",  32'(nlog[1]), 32'd2);
        chk("pend_addr0", 32'(addr_log[1][0]), 32'h20);
        chk("pend_addr1", 32'(addr_log[1][1]), 32'h60);
        chk("pend_vcnt",  32'(vcnt[1]), 32'd2);
        chk("pend_ch0",   32'(nlog[0]), 32'd0);

        // Download to ch1; core strobe on ch0 must be ignored meanwhile
        dly[1] = 3;
        clr();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        for (int i = 0; i < 4; i++) begin
            wait_free();
            ioctl_addr = AW'(i);
            ioctl_dout = 8'(8'hA0 + i);
            ioctl_wr   = 1'b1;
            if (i == 0) core_stb = 2'b01;
            step();
            ioctl_wr = 1'b0;
            core_stb = 2'b00;
            chk("dl_wait_hi", 32'(ioctl_wait), 32'd1);
        end
        wait_free();
        repeat (3) step();
        chk("dl_nlog", 32'(nlog[1]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("dl_we",   32'(we_log[1][i]),   32'd1);
            chk("dl_din",  32'(din_log[1][i]),  32'(8'hA0 + i));
            chk("dl_addr", 32'(addr_log[1][i]), 32'(i));
        end
        chk("dl_ch0",  32'(nlog[0]), 32'd0);
        chk("dl_vcnt", 32'(vcnt[1]), 32'd0);
        ioctl_download = 1'b0;
        step();

        // Mode switch: outstanding read completes, pending read discarded
        dly[0] = 5; rd_data[0] = 16'hCAFE;
        clr();
        core_addr[0 +: AW-1] = 21'h100; core_stb = 2'b01; step();
        core_addr[0 +: AW-1] = 21'h200; step();
        core_stb = 2'b00;
        ioctl_download = 1'b1;
        ioctl_index    = 8'd2;
        repeat (20) step();
        chk("ms_nlog", 32'(nlog[0]), 32'd1);
        chk("ms_vcnt", 32'(vcnt[0]), 32'd1);
        chk("ms_dout", 32'(core_dout[0 +: DW]), 32'hCAFE);
        chk("ms_busy", 32'(core_busy[0]), 32'd0);
        ioctl_download = 1'b0;
        repeat (10) step();
        chk("ms_nlog2", 32'(nlog[0]), 32'd1);

        // NCH=4, IDX_BASE=2: index 5 selects ch3 only
        clr();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd5;
        ioctl_addr     = 22'h15;
        ioctl_dout     = 8'h5A;
        ioctl_wr       = 1'b1;
        step();
        ioctl_wr = 1'b0;
        chk("sw_req",   32'(sd_req4), 32'h8);
        chk("sw_we",    32'(sd_we4[3]), 32'd1);
        chk("sw_din",   32'(sd_din4[31:24]), 32'h5A);
        chk("sw_addr",  32'(sd_addr4[3*AW +: AW]), 32'h15);
        chk("sw_wait4", 32'(ioctl_wait4), 32'd1);
        chk("sw_wait",  32'(ioctl_wait), 32'd0);
        chk("sw_main",  32'(sd_req), 32'(sd_ack));
        ioctl_download = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
